// File: rtl/cam_seq_pkg.sv
// cam_seq_pkg: opcodes, sensor register map and stream lengths shared by the camera sequencer
package cam_seq_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_TRIG  = 4'h1;
    localparam opcode_t OP_EXP_A = 4'h2;
    localparam opcode_t OP_EXP_B = 4'h3;
    localparam opcode_t OP_WIN_A = 4'h5;
    localparam opcode_t OP_WIN_B = 4'h6;

    localparam logic [7:0] REG_EXP_0 = 8'h08;
    localparam logic [7:0] REG_EXP_1 = 8'h09;
    localparam logic [7:0] REG_EXP_2 = 8'h0C;
    localparam logic [7:0] REG_EXP_3 = 8'h22;
    localparam logic [7:0] REG_EXP_4 = 8'h23;
    localparam logic [7:0] REG_EXP_5 = 8'h05;
    localparam logic [7:0] REG_EXP_6 = 8'h06;

    localparam logic [7:0] REG_WIN_0 = 8'h01;
    localparam logic [7:0] REG_WIN_1 = 8'h02;
    localparam logic [7:0] REG_WIN_2 = 8'h03;
    localparam logic [7:0] REG_WIN_3 = 8'h04;

    localparam logic [4:0] EXP_NBYTES = 5'd21;
    localparam logic [4:0] WIN_NBYTES = 5'd12;
    localparam logic [4:0] EXP_LAST   = EXP_NBYTES - 5'd1;
    localparam logic [4:0] WIN_LAST   = WIN_NBYTES - 5'd1;

    function automatic logic is_exp(input opcode_t op);
        return op == OP_EXP_A || op == OP_EXP_B;
    endfunction

    function automatic logic is_win(input opcode_t op);
        return op == OP_WIN_A || op == OP_WIN_B;
    endfunction

    function automatic logic [7:0] exp_reg(input logic [2:0] w);
        case (w)
            3'd0:    return REG_EXP_0;
            3'd1:    return REG_EXP_1;
            3'd2:    return REG_EXP_2;
            3'd3:    return REG_EXP_3;
            3'd4:    return REG_EXP_4;
            3'd5:    return REG_EXP_5;
            default: return REG_EXP_6;
        endcase
    endfunction

    function automatic logic [7:0] win_reg(input logic [1:0] w);
        case (w)
            2'd0:    return REG_WIN_0;
            2'd1:    return REG_WIN_1;
            2'd2:    return REG_WIN_2;
            default: return REG_WIN_3;
        endcase
    endfunction

endpackage

// File: rtl/cam_seq_byte_map.sv
// cam_seq_byte_map: maps (opcode, latched payload, byte index) to the outgoing I2C byte
//   op        in  4       latched opcode (exposure or window)
//   data      in  DATA_W  latched command payload
//   index     in  5       byte position in the stream (3 bytes per register write)
//   data_byte out 8       register address, then field hi byte, then field lo byte
//   last      out 1       index is the final byte of this opcode's stream
module cam_seq_byte_map
    import cam_seq_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] data,
    input  logic [4:0]        index,
    output logic [7:0]        data_byte,
    output logic              last
);

    logic [15:0] ef [8];
    logic [15:0] wf [4];
    logic [15:0] field;
    logic [7:0]  reg_addr;
    logic [2:0]  w;
    logic [1:0]  pos;
    logic        exp_op;
    logic        unused_data;

    // Payload bits above 62 carry nothing for the sensor.
    assign unused_data = ^data;

    always_comb begin
        ef[0]     = 16'(data[22:19]);
        ef[1]     = data[18:3];
        ef[2]     = 16'(data[35:23]);
        ef[3]     = 16'({data[37:36], 4'h0});
        ef[4]     = 16'({data[39:38], 4'h0});
        ef[5]     = 16'(data[51:40]);
        ef[6]     = 16'(data[62:52]);
        ef[7]     = '0;
        wf[0]     = 16'(data[10:0]);
        wf[1]     = 16'(data[22:11]);
        wf[2]     = 16'(data[33:23]);
        wf[3]     = 16'(data[45:34]);
        exp_op    = is_exp(op);
        w         = 3'(index / 5'd3);
        pos       = 2'(index % 5'd3);
        field     = exp_op ? ef[w] : wf[w[1:0]];
        reg_addr  = exp_op ? exp_reg(w) : win_reg(w[1:0]);
        data_byte = pos == 2'd0 ? reg_addr : pos == 2'd1 ? field[15:8] : field[7:0];
        last      = index == (exp_op ? EXP_LAST : WIN_LAST);
    end

endmodule

// File: rtl/cam_i2c_write_sequencer.sv
// cam_i2c_write_sequencer: decodes one camera command into I2C register-write bytes and trigger/config pulses
//   sysClk, rst                       clock, synchronous active-high reset
//   cmd_addr/cmd_data/cmd_valid/ready command input handshake (opcode in cmd_addr[3:0])
//   i2c_byte/_valid/_ready/_last      byte stream to the camera I2C interface, i2c_cam_id its target
//   cfg_compression/cfg_rgb/cfg_valid capture config, pulsed by exposure commands
//   trigger/trigger_cam/_index, timestamp  capture trigger pulse and its fields
//   cmd_error                         pulse on unknown opcode or out-of-range camera
//   busy                              byte stream in progress
//   err_count                         saturating error counter, present only with CAM_SEQ_ERR_CNT_EN
module cam_i2c_write_sequencer
    import cam_seq_pkg::*;
#(
    parameter  int NUM_CAMS = 2,
    parameter  int DATA_W   = 64,
    localparam int CAM_W    = (NUM_CAMS > 1) ? $clog2(NUM_CAMS) : 1
) (
    input  logic              sysClk,
    input  logic              rst,
    input  logic [7:0]        cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic [7:0]        i2c_byte,
    output logic              i2c_byte_valid,
    input  logic              i2c_byte_ready,
    output logic              i2c_byte_last,
    output logic [CAM_W-1:0]  i2c_cam_id,
    output logic [1:0]        cfg_compression,
    output logic              cfg_rgb,
    output logic              cfg_valid,
    output logic              trigger,
    output logic [CAM_W-1:0]  trigger_cam,
    output logic [15:0]       trigger_index,
    output logic [27:0]       timestamp,
`ifdef CAM_SEQ_ERR_CNT_EN
    output logic [7:0]        err_count,
`endif
    output logic              cmd_error,
    output logic              busy
);

    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] SEND      = 1'b1;
    localparam logic [5:0] CAM_LIMIT = 6'(NUM_CAMS);

    logic [0:0]        state;
    logic [4:0]        idx;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] data_q;
    logic [7:0]        map_byte;
    logic              map_last;
    logic [3:0]        op;
    logic [4:0]        cam;
    logic              accept;
    logic              trig_op;
    logic              stream_op;
    logic              bad;

    always_comb begin
        op        = cmd_addr[3:0];
        trig_op   = op == OP_TRIG;
        stream_op = is_exp(op) || is_win(op);
        // The low camera bit comes from the payload for triggers and from the A/B opcode variant otherwise.
        cam       = {cmd_addr[7:4], trig_op ? cmd_data[0] : (op == OP_EXP_B || op == OP_WIN_B)};
        bad       = !(trig_op || stream_op) || ({1'b0, cam} >= CAM_LIMIT);
        accept    = cmd_valid && cmd_ready;
    end

    cam_seq_byte_map #(.DATA_W(DATA_W)) u_map (
        .op        (op_q),
        .data      (data_q),
        .index     (idx),
        .data_byte (map_byte),
        .last      (map_last)
    );

    assign i2c_byte_valid = state == SEND;
    assign busy           = state == SEND;
    assign i2c_byte       = i2c_byte_valid ? map_byte : 8'h00;
    assign i2c_byte_last  = i2c_byte_valid && map_last;

    always_ff @(posedge sysClk) begin
        if (rst) begin
            state           <= IDLE;
            idx             <= '0;
            op_q            <= '0;
            data_q          <= '0;
            cmd_ready       <= 1'b1;
            i2c_cam_id      <= '0;
            cfg_compression <= '0;
            cfg_rgb         <= 1'b0;
            cfg_valid       <= 1'b0;
            trigger         <= 1'b0;
            trigger_cam     <= '0;
            trigger_index   <= '0;
            timestamp       <= '0;
            cmd_error       <= 1'b0;
        end else begin
            trigger   <= 1'b0;
            cfg_valid <= 1'b0;
            cmd_error <= 1'b0;
            if (accept) begin
                // Every accepted command drops cmd_ready for at least one cycle.
                cmd_ready <= 1'b0;
                if (bad) begin
                    cmd_error <= 1'b1;
                end else if (trig_op) begin
                    trigger       <= 1'b1;
                    trigger_cam   <= cam[CAM_W-1:0];
                    trigger_index <= cmd_data[16:1];
                    timestamp     <= cmd_data[44:17];
                end else begin
                    state      <= SEND;
                    idx        <= '0;
                    op_q       <= op;
                    data_q     <= cmd_data;
                    i2c_cam_id <= cam[CAM_W-1:0];
                    if (is_exp(op)) begin
                        cfg_valid       <= 1'b1;
                        cfg_compression <= cmd_data[1:0];
                        cfg_rgb         <= cmd_data[2];
                    end
                end
            end else if (state == IDLE) begin
                cmd_ready <= 1'b1;
            end else if (i2c_byte_ready) begin
                if (map_last) begin
                    state     <= IDLE;
                    idx       <= '0;
                    cmd_ready <= 1'b1;
                end else begin
                    idx <= idx + 5'd1;
                end
            end
        end
    end

`ifdef CAM_SEQ_ERR_CNT_EN
    always_ff @(posedge sysClk) begin
        if (rst)
            err_count <= '0;
        else if (accept && bad && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`endif

endmodule
